// File: rtl/a51_seq_pkg.sv
// Shared types and defaults for the A5/1 phase sequencer: the state
// enum, the default per-phase cycle counts and the phase-limit helper.
package a51_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEY,
      ST_FRAME,
      ST_MIX,
      ST_OUT,
      ST_DONE
   } seq_state_e;

   localparam int unsigned DEF_KEY_LEN   = 64;
   localparam int unsigned DEF_FRAME_LEN = 22;
   localparam int unsigned DEF_MIX_LEN   = 100;
   localparam int unsigned DEF_OUT_LEN   = 228;

   // Terminal count (LEN-1) of the phase held in st; 0 outside active phases.
   function automatic int unsigned phase_last(input seq_state_e  st,
                                              input int unsigned key_len,
                                              input int unsigned frame_len,
                                              input int unsigned mix_len,
                                              input int unsigned out_len);
      case (st)
         ST_KEY:   return key_len - 1;
         ST_FRAME: return frame_len - 1;
         ST_MIX:   return mix_len - 1;
         ST_OUT:   return out_len - 1;
         default:  return 0;
      endcase
   endfunction

endpackage

// File: rtl/a51_phase_counter.sv
// Phase index counter: synchronous clear, advance qualifier and a
// terminal-count flag against a limit that changes with the phase.
module a51_phase_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign tc_o    = (count_q == limit_i);
   assign count_o = count_q;

   // Next count: clear wins, otherwise wrap to 0 at the limit or increment.
   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tc_o ? '0 : count_q + 1'b1;
      end
   end

   // Counter register with asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (clr) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/a51_phase_sequencer.sv
// Phase sequencer for the A5/1 keystream core: walks key load, frame load,
// mixing and output with programmable lengths, one-shot or continuous,
// auto-incrementing the frame number between continuous bursts.
module a51_phase_sequencer
   import a51_seq_pkg::*;
#(
   parameter int unsigned KEY_LEN   = DEF_KEY_LEN,
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
   parameter int unsigned MIX_LEN   = DEF_MIX_LEN,
   parameter int unsigned OUT_LEN   = DEF_OUT_LEN,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned FRAME_W   = 22
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               enable,
   input  logic               start,
   input  logic               abort,
   input  logic               cont,
   input  logic               frame_load,
   input  logic [FRAME_W-1:0] frame_in,
   output logic [CNT_W-1:0]   count,
   output logic               stage_key,
   output logic               stage_frame,
   output logic               stage_mix,
   output logic               stage_out,
   output logic               last,
   output logic               burst_done,
   output logic               done,
   output logic [FRAME_W-1:0] frame_num
);

   seq_state_e         state_q;
   logic [FRAME_W-1:0] frame_num_q;
   logic               burst_done_q;

   logic               active;
   logic               idle_or_done;
   logic               cnt_tc;
   logic               phase_end;
   logic [CNT_W-1:0]   limit;

   assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign active       = !idle_or_done;
   assign limit        = CNT_W'(phase_last(state_q, KEY_LEN, FRAME_LEN, MIX_LEN, OUT_LEN));
   // The counter's terminal flag is meaningless in IDLE/DONE, so gate it.
   assign phase_end    = active && enable && cnt_tc && !abort;

   a51_phase_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk     (clk),
      .clr     (clr),
      .clear_i (abort),
      .en_i    (active && enable),
      .limit_i (limit),
      .count_o (count),
      .tc_o    (cnt_tc)
   );

   // Phase FSM with frame number and burst-complete pulse.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         frame_num_q  <= '0;
         burst_done_q <= 1'b0;
      end else begin
         burst_done_q <= 1'b0;
         // Frame loading is independent of enable; in the same cycle as
         // start the new run therefore uses frame_in.
         if (idle_or_done && frame_load) frame_num_q <= frame_in;
         if (abort) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: if (start && enable) state_q <= ST_KEY;
               ST_KEY:           if (phase_end) state_q <= ST_FRAME;
               ST_FRAME:         if (phase_end) state_q <= ST_MIX;
               ST_MIX:           if (phase_end) state_q <= ST_OUT;
               ST_OUT: begin
                  if (phase_end) begin
                     burst_done_q <= 1'b1;
                     if (cont) begin
                        frame_num_q <= frame_num_q + 1'b1;
                        state_q     <= ST_KEY;
                     end else begin
                        state_q     <= ST_DONE;
                     end
                  end
               end
               default:          state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign stage_key   = (state_q == ST_KEY);
   assign stage_frame = (state_q == ST_FRAME);
   assign stage_mix   = (state_q == ST_MIX);
   assign stage_out   = (state_q == ST_OUT);
   assign done        = (state_q == ST_DONE);
   assign last        = active && cnt_tc;
   assign burst_done  = burst_done_q;
   assign frame_num   = frame_num_q;

endmodule

// File: tb/tb_a51_phase_sequencer.sv
// Bench for a51_phase_sequencer: per-cycle scoreboard against a run-position
// model, plus directed timing checks and a minimum-length instance.
module tb_a51_phase_sequencer;

   localparam int TOTAL = 414;

   typedef struct packed {
      logic [7:0]  count;
      logic        sk, sf, sm, so, last, bd, done;
      logic [21:0] fn;
   } obs_t;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        enable = 1'b0, start = 1'b0, abort = 1'b0, cont = 1'b0, frame_load = 1'b0;
   logic [21:0] frame_in = '0;
   logic [7:0]  count;
   logic        stage_key, stage_frame, stage_mix, stage_out, last, burst_done, done;
   logic [21:0] frame_num;

   logic        s_enable = 1'b0, s_start = 1'b0, s_abort = 1'b0, s_cont = 1'b0, s_frame_load = 1'b0;
   logic [21:0] s_frame_in = '0;
   logic [0:0]  s_count;
   logic        s_sk, s_sf, s_sm, s_so, s_last, s_bd, s_done;
   logic [21:0] s_frame_num;

   int n_tests = 0;
   int n_fail  = 0;

   obs_t exp_q[$];

   // Model: idle(0)/running(1)/done(2) plus a position within the whole run.
   int lens[4] = '{64, 22, 100, 228};
   int m_mode = 0, m_pos = 0, m_frame = 0;
   bit m_bd = 0;

   int          edge_n = 0, obs_edge = 0;
   logic        obs_done, obs_bd;
   logic [21:0] obs_fn;

   a51_phase_sequencer dut (
      .clk(clk), .clr(clr), .enable(enable), .start(start), .abort(abort),
      .cont(cont), .frame_load(frame_load), .frame_in(frame_in),
      .count(count), .stage_key(stage_key), .stage_frame(stage_frame),
      .stage_mix(stage_mix), .stage_out(stage_out), .last(last),
      .burst_done(burst_done), .done(done), .frame_num(frame_num)
   );

   a51_phase_sequencer #(
      .KEY_LEN(1), .FRAME_LEN(1), .MIX_LEN(1), .OUT_LEN(1), .CNT_W(1), .FRAME_W(22)
   ) dut_small (
      .clk(clk), .clr(clr), .enable(s_enable), .start(s_start), .abort(s_abort),
      .cont(s_cont), .frame_load(s_frame_load), .frame_in(s_frame_in),
      .count(s_count), .stage_key(s_sk), .stage_frame(s_sf),
      .stage_mix(s_sm), .stage_out(s_so), .last(s_last),
      .burst_done(s_bd), .done(s_done), .frame_num(s_frame_num)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   function automatic int m_seg();
      int rem = m_pos;
      int seg = 0;
      while (rem >= lens[seg]) begin
         rem -= lens[seg];
         seg++;
      end
      return seg;
   endfunction

   function automatic int m_cnt();
      int rem = m_pos;
      for (int s = 0; s < 4; s++) begin
         if (rem < lens[s]) return rem;
         rem -= lens[s];
      end
      return 0;
   endfunction

   function automatic obs_t model_obs();
      obs_t o = '0;
      int   seg, c;
      o.fn   = 22'(m_frame);
      o.bd   = m_bd;
      o.done = (m_mode == 2);
      if (m_mode == 1) begin
         seg     = m_seg();
         c       = m_cnt();
         o.count = 8'(c);
         o.sk    = (seg == 0);
         o.sf    = (seg == 1);
         o.sm    = (seg == 2);
         o.so    = (seg == 3);
         o.last  = (c == lens[seg] - 1);
      end
      return o;
   endfunction

   task automatic model_step(input bit st, en, ab, ct, fl, input logic [21:0] fi);
      m_bd = 0;
      if (m_mode != 1 && fl) m_frame = int'(fi);
      if (ab) begin
         m_mode = 0;
         m_pos  = 0;
      end else if (m_mode != 1) begin
         if (st && en) begin
            m_mode = 1;
            m_pos  = 0;
         end
      end else if (en) begin
         if (m_pos == TOTAL - 1) begin
            m_bd  = 1;
            m_pos = 0;
            if (ct) m_frame = (m_frame + 1) % (1 << 22);
            else    m_mode  = 2;
         end else begin
            m_pos++;
         end
      end
   endtask

   // One clock of stimulus: sample the settled DUT, drive inputs, predict.
   task automatic issue(input bit st, en, ab, ct, fl, input logic [21:0] fi);
      @(negedge clk);
      obs_done   = done;
      obs_bd     = burst_done;
      obs_fn     = frame_num;
      obs_edge   = edge_n;
      start      = st;
      enable     = en;
      abort      = ab;
      cont       = ct;
      frame_load = fl;
      frame_in   = fi;
      model_step(st, en, ab, ct, fl, fi);
      exp_q.push_back(model_obs());
      edge_n++;
   endtask

   task automatic advance_to(input int seg, input int cnt);
      for (int i = 0; i < 2000; i++) begin
         if (m_mode == 1 && m_seg() == seg && m_cnt() == cnt) return;
         issue(0, 1, 0, 0, 0, '0);
      end
      timeout("advance_to");
   endtask

   // Enable held high until done; cont kept high only while the frame number
   // is all-ones when mode=1. Times are edge counts with the start edge as 1.
   task automatic run_to_done(input int mode, input int t0, output int rel_done, output int rel_bd1);
      bit ct;
      rel_done = -1;
      rel_bd1  = -1;
      for (int i = 0; i < 3000; i++) begin
         ct = (mode == 1) && (m_frame == 22'h3FFFFF);
         issue(0, 1, 0, ct, 0, '0);
         if (obs_bd && rel_bd1 < 0) rel_bd1 = obs_edge - t0 + 1;
         if (obs_done) begin
            rel_done = obs_edge - t0 + 1;
            return;
         end
      end
      timeout("run_to_done");
   endtask

   // Monitor: one scoreboard entry per predicted clock edge.
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {count, stage_key, stage_frame, stage_mix, stage_out, last, burst_done, done, frame_num};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               if (n_fail <= 20)
                  $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, a, e);
            end
         end
      end
   end

   initial begin
      int t0, rd, rb, b2;
      bit st, en, ab, ct, fl;

      // Reset state while clr is held.
      #12;
      check("reset_count", 32'(count), 0);
      check("reset_flags", {stage_key, stage_frame, stage_mix, stage_out, last, burst_done, done}, 0);
      check("reset_frame", 32'(frame_num), 0);
      @(negedge clk);
      clr = 1'b0;

      // Default one-shot run.
      issue(1, 1, 0, 0, 0, '0);
      t0 = edge_n;
      run_to_done(0, t0, rd, rb);
      check("oneshot_done_cycle", 32'(rd), 415);
      check("oneshot_bd_cycle", 32'(rb), 415);
      issue(0, 1, 0, 0, 0, '0);
      check("oneshot_bd_clear", 32'(obs_bd), 0);

      // Stall at KEY count 10 for five cycles.
      issue(1, 1, 0, 0, 0, '0);
      t0 = edge_n;
      advance_to(0, 10);
      repeat (5) issue(0, 0, 0, 0, 0, '0);
      run_to_done(0, t0, rd, rb);
      check("stall_done_cycle", 32'(rd), 420);

      // Continuous run from the top frame number, wrapping to zero.
      issue(0, 0, 0, 0, 1, 22'h3FFFFF);
      issue(1, 1, 0, 1, 0, '0);
      t0 = edge_n;
      run_to_done(1, t0, rd, rb);
      check("cont_first_bd", 32'(rb), 415);
      check("cont_done_cycle", 32'(rd), 829);
      b2 = rd - rb;
      check("cont_bd_spacing", 32'(b2), 414);
      check("cont_frame_wrap", 32'(obs_fn), 0);

      // Abort with start in FRAME, start in MIX, frame_load in OUT.
      issue(1, 1, 0, 0, 0, '0);
      advance_to(1, 3);
      issue(1, 1, 1, 0, 0, '0);
      issue(0, 0, 0, 0, 0, '0);
      check("abort_start_idle", {32'(obs_done), 32'(stage_frame)}, 0);
      issue(1, 1, 0, 0, 0, '0);
      advance_to(2, 5);
      issue(1, 1, 0, 0, 0, '0);
      advance_to(3, 7);
      issue(0, 1, 0, 0, 1, 22'h155555);
      issue(0, 1, 0, 0, 0, '0);
      check("frame_load_in_out", 32'(obs_fn), 0);
      issue(0, 1, 1, 0, 0, '0);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 9) < 8);
         st = ($urandom_range(0, 15) == 0);
         ab = ($urandom_range(0, 199) < 2);
         ct = $urandom_range(0, 1);
         fl = ($urandom_range(0, 19) == 0);
         issue(st, en, ab, ct, fl, 22'($urandom));
      end
      issue(0, 0, 1, 0, 0, '0);

      // Asynchronous clear in MIX at count 37, checked before the next edge.
      issue(0, 0, 0, 0, 1, 22'h012345);
      issue(1, 1, 0, 0, 0, '0);
      advance_to(2, 37);
      @(negedge clk);
      check("pre_clr_count", 32'(count), 37);
      #2;
      clr = 1'b1;
      #1;
      check("async_clr_count", 32'(count), 0);
      check("async_clr_flags", {stage_key, stage_frame, stage_mix, stage_out, last, burst_done, done}, 0);
      check("async_clr_frame", 32'(frame_num), 0);
      start = 0; enable = 0; abort = 0; cont = 0; frame_load = 0;
      m_mode = 0; m_pos = 0; m_frame = 0; m_bd = 0;
      #1;
      clr = 1'b0;

      // Minimum lengths: one cycle per phase, done after the fifth edge.
      @(negedge clk);
      s_start  = 1'b1;
      s_enable = 1'b1;
      @(negedge clk);
      s_start  = 1'b0;
      check("small_key", {s_sk, s_sf, s_sm, s_so, s_last, 1'(s_count)}, 6'b100010);
      @(negedge clk);
      check("small_frame", {s_sk, s_sf, s_sm, s_so, s_last}, 5'b01001);
      @(negedge clk);
      check("small_mix", {s_sk, s_sf, s_sm, s_so, s_last}, 5'b00101);
      @(negedge clk);
      check("small_out", {s_sk, s_sf, s_sm, s_so, s_last, s_done}, 6'b000110);
      @(negedge clk);
      check("small_done", {s_done, s_bd, s_so}, 3'b110);

      repeat (3) @(negedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/a51_phase_sequencer.md
# a51_phase_sequencer

Parametrised phase sequencer for the A5/1 keystream core. It steps the LFSR datapath through key load, frame load, mixing and keystream output, with a programmable cycle count per phase. A run is one-shot or continuous, and continuous runs auto-increment a 22-bit frame number between bursts. It sits between the top-level control and the three-register LFSR datapath, and drives that datapath's phase selects and bit index.

## Interface
Parameters:
- KEY_LEN, 64, cycles in key-load phase (≥1)
- FRAME_LEN, 22, cycles in frame-load phase (≥1)
- MIX_LEN, 100, cycles in mixing phase (≥1)
- OUT_LEN, 228, cycles in output phase (≥1)
- CNT_W, 8, phase counter width; 2^CNT_W ≥ max(*_LEN)
- FRAME_W, 22, frame number width

Ports (one clock; reset `clr` is asynchronous, active-high):
- clk  in  1  clock, rising edge
- clr  in  1  async active-high reset
- enable  in  1  advance qualifier; low freezes state, counter and frame number
- start  in  1  begin run; honoured in IDLE or DONE only
- abort  in  1  synchronous return to IDLE; ignores enable
- cont  in  1  continuous mode, sampled on the last OUT cycle
- frame_load  in  1  load frame_in into frame_num; honoured in IDLE or DONE only
- frame_in  in  FRAME_W  frame number to load
- count  out  CNT_W  index within current phase, 0..LEN-1
- stage_key, stage_frame, stage_mix, stage_out  out  1 each  one-hot phase flags; all low in IDLE and DONE
- last  out  1  count == current phase LEN-1 while in an active phase
- burst_done  out  1  one-cycle pulse after each completed OUT phase
- done  out  1  high while in DONE
- frame_num  out  FRAME_W  current frame number

## Operation
- States: IDLE, KEY, FRAME, MIX, OUT, DONE. State and counter are registered; all outputs decode from these registers.
- Reset values: IDLE, count=0, frame_num=0, burst_done=0, all other outputs 0.
- IDLE or DONE with start=1 and enable=1: go to KEY, count=0.
- Active phase with enable=1 and last=0: count+1.
- Active phase with enable=1 and last=1: count←0 and go to the next phase (KEY→FRAME→MIX→OUT).
- OUT with last=1 and enable=1: burst_done pulses on the next cycle. Then:
  - cont=1: frame_num+1 (wraps 2^FRAME_W-1→0) and go to KEY, with no idle cycle.
  - cont=0: go to DONE; frame_num is unchanged.
- enable=0: hold everything. burst_done still clears after its single cycle.
- abort=1: go to IDLE with count=0 on the next edge, regardless of enable. abort beats start in the same cycle. frame_num is kept.
- start during an active phase is ignored. frame_load outside IDLE/DONE is ignored. frame_load does not depend on enable.
- frame_load and start in the same cycle: both take effect; the run uses frame_in.

## Timing
- start sampled at edge N → stage_key=1 and count=0 after edge N.
- A full run with enable held high takes KEY_LEN+FRAME_LEN+MIX_LEN+OUT_LEN cycles in active phases (default 414), followed by DONE.
- done asserts the cycle after the last OUT cycle. burst_done asserts in the same cycle as done.
- Continuous mode: stage_key reasserts the cycle after the last OUT cycle, with the incremented frame_num visible in that same cycle.
- clr is asynchronous: outputs reach reset values without waiting for clk, including mid-run.

## Structure
- Package a51_seq_pkg holds:
  - the state enum (IDLE, KEY, FRAME, MIX, OUT, DONE)
  - default phase lengths
  - a function returning LEN-1 for a given state
- Sub-module a51_phase_counter: a CNT_W counter with clear, enable and terminal-count flag. The FSM instantiates it once and feeds it the current phase limit.

## Test plan
- Reset: assert clr mid-MIX (count=37), asynchronously → state IDLE, count=0, frame_num=0 before the next clk edge.
- Default one-shot: start, enable high. Check:
  - stage_key for 64 cycles, stage_frame for 22, stage_mix for 100, stage_out for 228
  - last high on count 63, 21, 99 and 227
  - done and burst_done on cycle 415; burst_done low on cycle 416
- Stall: drop enable for 5 cycles at KEY count=10 → count stays 10 with stage_key held; the run completes 5 cycles late.
- Continuous: frame_load with frame_in=0x3FFFFF, then start with cont=1. After OUT:
  - frame_num=0 and stage_key=1 in the same cycle
  - second burst_done after another 414 cycles
  - with cont=0 at that point, done=1.
- Abort and collisions:
  - abort+start together in FRAME → IDLE
  - start in MIX → ignored
  - frame_load in OUT → frame_num unchanged
- Small parameters: all *_LEN=1, CNT_W=1 → one cycle per phase; done on cycle 5 after start.
